// File: rtl/gate_bank_checker_pkg.sv
// gate_chk_pkg: FSM states and gate-bank response bit layout shared by the checker.
package gate_chk_pkg;
  localparam int RESP_W = 7;
  localparam int N_T = 0, A_D = 1, O_R = 2, N_D = 3, N_R = 4, X_R = 5, XN_R = 6;
  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_e;
endpackage

// File: rtl/gate_bank_checker_if.sv
// gate_bank_checker_if: control, stimulus and status bundle between the checker and its environment.
interface gate_bank_checker_if import gate_chk_pkg::*; #(parameter int ERR_W = 8);
  logic              i_start;
  logic              i_abort;
  logic [RESP_W-1:0] i_resp;
  logic              o_a;
  logic              o_b;
  logic              o_busy;
  logic              o_done;
  logic              o_pass;
  logic [ERR_W-1:0]  o_err_count;
  logic [1:0]        o_first_fail_vec;
  logic [RESP_W-1:0] o_first_fail_mask;
  modport master (output i_start, i_abort, i_resp,
                  input  o_a, o_b, o_busy, o_done, o_pass, o_err_count, o_first_fail_vec, o_first_fail_mask);
  modport slave  (input  i_start, i_abort, i_resp,
                  output o_a, o_b, o_busy, o_done, o_pass, o_err_count, o_first_fail_vec, o_first_fail_mask);
endinterface

// File: rtl/gate_bank_checker_expect.sv
// gate_expect: golden gate-bank response for one (a,b) vector.
module gate_expect import gate_chk_pkg::*; (
  input  logic              i_a,
  input  logic              i_b,
  output logic [RESP_W-1:0] o_exp
);
  always_comb begin
    o_exp       = '0;
    o_exp[N_T]  = ~i_a;
    o_exp[A_D]  = i_a & i_b;
    o_exp[O_R]  = i_a | i_b;
    o_exp[N_D]  = ~(i_a & i_b);
    o_exp[N_R]  = ~(i_a | i_b);
    o_exp[X_R]  = i_a ^ i_b;
    o_exp[XN_R] = ~(i_a ^ i_b);
  end
endmodule

// File: rtl/gate_bank_checker.sv
// gate_bank_checker: sweeps all (a,b) vectors into the gate bank and checks the settled responses.
module gate_bank_checker import gate_chk_pkg::*; #(
  parameter int SETTLE_CYC = 2,
  parameter int PASSES     = 1,
  parameter int ERR_W      = 8
) (
  input logic clk,
  input logic rst_n,
  gate_bank_checker_if.slave bus
);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int PW = $clog2(PASSES) + 1;
  state_e            r_state;
  logic [1:0]        r_idx;
  logic [SW-1:0]     r_cnt;
  logic [PW-1:0]     r_pass_n;
  logic              r_a, r_b, r_pass;
  logic [ERR_W-1:0]  r_err;
  logic [1:0]        r_ffv;
  logic [RESP_W-1:0] r_ffm;
  logic [RESP_W-1:0] w_exp, w_diff;
  logic              w_bad;
  gate_expect u_expect (.i_a(r_a), .i_b(r_b), .o_exp(w_exp));
  assign w_diff = bus.i_resp ^ w_exp;
  assign w_bad  = |w_diff;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_pass_n <= '0;
      r_a      <= 1'b0;
      r_b      <= 1'b0;
      r_pass   <= 1'b0;
      r_err    <= '0;
      r_ffv    <= '0;
      r_ffm    <= '0;
    end else if (bus.i_abort) begin
      // abort also masks a start in IDLE and discards a CHECK sample
      if (r_state != IDLE) begin
        r_state <= IDLE;
        r_pass  <= 1'b0;
      end
    end else begin
      case (r_state)
        IDLE: if (bus.i_start) begin
          r_state  <= DRIVE;
          r_err    <= '0;
          r_pass   <= 1'b0;
          r_ffv    <= '0;
          r_ffm    <= '0;
          r_idx    <= '0;
          r_pass_n <= '0;
        end
        DRIVE: begin
          {r_a, r_b} <= r_idx;
          r_cnt      <= SW'(SETTLE_CYC);
          r_state    <= SETTLE;
        end
        SETTLE: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == SW'(1)) r_state <= CHECK;
        end
        CHECK: begin
          if (w_bad) begin
            if (~&r_err) r_err <= r_err + 1'b1;
            // err_count only grows within a run, so zero marks the first failure
            if (r_err == '0) begin
              r_ffv <= {r_a, r_b};
              r_ffm <= w_diff;
            end
          end
          if (r_idx != 2'd3) begin
            r_idx   <= r_idx + 2'd1;
            r_state <= DRIVE;
          end else if (r_pass_n != PW'(PASSES - 1)) begin
            r_idx    <= '0;
            r_pass_n <= r_pass_n + 1'b1;
            r_state  <= DRIVE;
          end else r_state <= DONE;
        end
        DONE: begin
          r_pass  <= (r_err == '0);
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.o_a               = r_a;
  assign bus.o_b               = r_b;
  assign bus.o_busy            = (r_state == DRIVE) || (r_state == SETTLE) || (r_state == CHECK);
  assign bus.o_done            = (r_state == DONE);
  assign bus.o_pass            = r_pass;
  assign bus.o_err_count       = r_err;
  assign bus.o_first_fail_vec  = r_ffv;
  assign bus.o_first_fail_mask = r_ffm;
endmodule
